ta_ldd_cap_seq: RTL and testbench

//  Queued laser-driver capture-window sequencer on the clk200 domain. Buffers up to DEPTH window

---
 rtl/ta_ldd_cap_seq_if.sv | 14 +
 rtl/ta_ldd_cap_seq.sv | 76 +++++++
 tb/tb_ta_ldd_cap_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ta_ldd_cap_seq_if.sv
// ta_ldd_cap_seq_if: window-command handshake between ranging control and the capture sequencer
interface ta_ldd_cap_seq_if #(
  parameter int TOP0_0 = 3,
  parameter int CNT_W  = 16,
  parameter int GAP_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [TOP0_0-1:0] cmd_wdis;
  logic [CNT_W-1:0]  cmd_len;
  logic [GAP_W-1:0]  cmd_gap;
  modport master (output cmd_valid, cmd_wdis, cmd_len, cmd_gap, input cmd_ready);
  modport slave  (input cmd_valid, cmd_wdis, cmd_len, cmd_gap, output cmd_ready);
endinterface

// File: rtl/ta_ldd_cap_seq.sv
// ta_ldd_cap_seq: queued laser-driver capture-window sequencer with gap, done pulse and abort/flush
module ta_ldd_cap_seq #(
  parameter int TOP0_0 = 3,
  parameter int CNT_W  = 16,
  parameter int GAP_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk200,
  input  logic                     rst,
  ta_ldd_cap_seq_if.slave          cmd,
  input  logic                     abort,
  output logic [TOP0_0-1:0]        wdis,
  output logic                     win_act,
  output logic                     win_done,
  output logic                     capr_rdy,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int A_W = $clog2(DEPTH);
  localparam int L_W = A_W + 1;
  localparam int C_W = CNT_W > GAP_W ? CNT_W : GAP_W;
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  state_t            state, state_n;
  logic [TOP0_0-1:0] mem_wdis [DEPTH];
  logic [CNT_W-1:0]  mem_len  [DEPTH];
  logic [GAP_W-1:0]  mem_gap  [DEPTH];
  logic [A_W-1:0]    wp, rp;
  logic [C_W-1:0]    cnt;
  logic [GAP_W-1:0]  gap_r, fin_gap;
  logic [L_W-1:0]    lvl_n;
  logic              full, push, pop, fin;
  assign full          = fifo_level == L_W'(DEPTH);
  assign pop           = state == IDLE && fifo_level != '0 && !abort;
  assign cmd.cmd_ready = !rst && !abort && (!full || pop);
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign fin           = !abort && ((state == ON && cnt == C_W'(1)) || (pop && mem_len[rp] == '0));
  assign fin_gap       = state == ON ? gap_r : mem_gap[rp];
  assign lvl_n         = abort ? '0 : fifo_level + L_W'(push) - L_W'(pop);
  always_comb begin
    state_n = abort ? IDLE :
              fin ? (fin_gap != '0 ? GAP : IDLE) :
              pop ? ON :
              (state == GAP && cnt == '0) ? IDLE : state;
  end
  always_ff @(posedge clk200) begin
    if (push) begin
      mem_wdis[wp] <= cmd.cmd_wdis;
      mem_len[wp]  <= cmd.cmd_len;
      mem_gap[wp]  <= cmd.cmd_gap;
    end
  end
  always_ff @(posedge clk200) begin
    if (rst) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      cnt        <= '0;
      gap_r      <= '0;
      wdis       <= '0;
      win_act    <= 1'b0;
      win_done   <= 1'b0;
      capr_rdy   <= 1'b0;
    end else begin
      state      <= state_n;
      fifo_level <= lvl_n;
      capr_rdy   <= state_n == IDLE && lvl_n == '0;
      win_done   <= fin;
      win_act    <= state_n == ON;
      wdis       <= state_n == ON ? (pop ? mem_wdis[rp] : wdis) : '0;
      cnt        <= fin ? C_W'(fin_gap) : pop ? C_W'(mem_len[rp]) : cnt != '0 ? cnt - C_W'(1) : cnt;
      wp         <= abort ? '0 : push ? wp + A_W'(1) : wp;
      rp         <= abort ? '0 : pop ? rp + A_W'(1) : rp;
      gap_r      <= pop ? mem_gap[rp] : gap_r;
    end
  end
endmodule

// File: tb/tb_ta_ldd_cap_seq.sv
// tb_ta_ldd_cap_seq: directed vectors for the capture-window sequencer
module tb_ta_ldd_cap_seq;
  logic       clk200 = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic [2:0] wdis;
  logic       win_act, win_done, capr_rdy;
  logic [2:0] fifo_level;
  int         checks = 0;
  int         failures = 0;
  int         n_nz, n_done;
  ta_ldd_cap_seq_if #(.TOP0_0(3), .CNT_W(16), .GAP_W(8)) cif ();
  ta_ldd_cap_seq #(.TOP0_0(3), .CNT_W(16), .GAP_W(8), .DEPTH(4)) dut (
    .clk200(clk200), .rst(rst), .cmd(cif.slave), .abort(abort), .wdis(wdis),
    .win_act(win_act), .win_done(win_done), .capr_rdy(capr_rdy), .fifo_level(fifo_level)
  );
  always #5 clk200 = ~clk200;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk200);
    #1;
    if (wdis != 3'd0) n_nz++;
    if (win_done) n_done++;
  endtask
  task automatic set_cmd(input logic v, input logic [2:0] w, input logic [15:0] l, input logic [7:0] g);
    cif.cmd_valid = v;
    cif.cmd_wdis  = w;
    cif.cmd_len   = l;
    cif.cmd_gap   = g;
  endtask
  logic [2:0] e1_w [7] = '{5, 5, 5, 0, 0, 0, 0};
  logic       e1_d [7] = '{0, 0, 0, 1, 0, 0, 0};
  logic       e1_c [7] = '{0, 0, 0, 0, 0, 0, 1};
  logic [2:0] e2_w [15] = '{7, 7, 0, 1, 1, 0, 2, 2, 0, 3, 3, 0, 4, 4, 0};
  initial begin
    set_cmd(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_wdis", wdis, 0);
    chk("rst_capr", capr_rdy, 0);
    chk("rst_ready", cif.cmd_ready, 0);
    chk("rst_act", win_act, 0);
    chk("rst_level", fifo_level, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_capr", capr_rdy, 1);
    chk("post_rst_ready", cif.cmd_ready, 1);
    // 1) single window len=3 gap=2
    set_cmd(1, 5, 3, 2);
    tick();
    chk("t1_level", fifo_level, 1);
    chk("t1_capr_busy", capr_rdy, 0);
    set_cmd(0, 3, 9, 0);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("t1_wdis%0d", k), wdis, e1_w[k]);
      chk($sformatf("t1_done%0d", k), win_done, e1_d[k]);
      chk($sformatf("t1_capr%0d", k), capr_rdy, e1_c[k]);
    end
    // 2) long window while four short ones queue up behind it
    set_cmd(1, 7, 6, 0);
    tick();
    set_cmd(1, 1, 2, 0);
    tick();
    chk("t2_first", wdis, 7);
    set_cmd(1, 2, 2, 0);
    tick();
    set_cmd(1, 3, 2, 0);
    tick();
    set_cmd(1, 4, 2, 0);
    tick();
    chk("t2_level_full", fifo_level, 4);
    set_cmd(1, 6, 2, 0);
    #1 chk("t2_ready_full", cif.cmd_ready, 0);
    set_cmd(0, 0, 0, 0);
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("t2_wdis%0d", k), wdis, e2_w[k]);
    end
    chk("t2_dones", n_done, 5);
    chk("t2_capr", capr_rdy, 1);
    chk("t2_level_end", fifo_level, 0);
    // 3) empty window
    set_cmd(1, 6, 0, 0);
    tick();
    chk("t3_level", fifo_level, 1);
    set_cmd(0, 0, 0, 0);
    n_nz = 0;
    n_done = 0;
    repeat (4) tick();
    chk("t3_nz", n_nz, 0);
    chk("t3_done", n_done, 1);
    chk("t3_capr", capr_rdy, 1);
    // 4) abort during second cycle of a len=10 window with two queued
    set_cmd(1, 2, 10, 0);
    tick();
    set_cmd(1, 3, 2, 0);
    tick();
    chk("t4_win", wdis, 2);
    set_cmd(1, 4, 2, 0);
    tick();
    chk("t4_level", fifo_level, 2);
    set_cmd(0, 0, 0, 0);
    abort = 1'b1;
    n_done = 0;
    tick();
    abort = 1'b0;
    chk("t4_wdis", wdis, 0);
    chk("t4_act", win_act, 0);
    chk("t4_flush", fifo_level, 0);
    n_nz = 0;
    repeat (5) tick();
    chk("t4_nz", n_nz, 0);
    chk("t4_nodone", n_done, 0);
    chk("t4_capr", capr_rdy, 1);
    // 5) push dropped under abort; push at full with simultaneous pop
    abort = 1'b1;
    set_cmd(1, 5, 3, 0);
    #1 chk("t5_ready_abort", cif.cmd_ready, 0);
    tick();
    chk("t5_level_abort", fifo_level, 0);
    abort = 1'b0;
    set_cmd(1, 1, 3, 0);
    tick();
    set_cmd(1, 2, 1, 0);
    tick();
    set_cmd(1, 3, 1, 0);
    tick();
    set_cmd(1, 4, 1, 0);
    tick();
    set_cmd(1, 5, 1, 0);
    tick();
    chk("t5_level_full", fifo_level, 4);
    set_cmd(1, 6, 1, 0);
    #1 chk("t5_ready_pop", cif.cmd_ready, 1);
    tick();
    chk("t5_level_keep", fifo_level, 4);
    chk("t5_wdis", wdis, 2);
    set_cmd(0, 0, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_clear", fifo_level, 0);
    // 6) reset mid-window
    set_cmd(1, 3, 10, 0);
    tick();
    set_cmd(0, 0, 0, 0);
    tick();
    tick();
    chk("t6_win", wdis, 3);
    rst = 1'b1;
    tick();
    chk("t6_wdis", wdis, 0);
    chk("t6_act", win_act, 0);
    chk("t6_capr", capr_rdy, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_ready", cif.cmd_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_capr_rel", capr_rdy, 1);
    chk("t6_level_rel", fifo_level, 0);
    chk("t6_wdis_rel", wdis, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
